// File: rtl/perceptron_update.sv
// Purpose : gradient-descent update stage for a two-input sigmoid perceptron (Q8.24).
// Latency : start accepted at edge E0; weights change at E7; o_done pulses in the cycle after E8.
// Backpr. : none; i_start/i_load are honoured only while idle and are dropped, not queued, when busy.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   i_start, i_load       update request / weight load request (idle only, load has priority)
//   i_w0_ld/i_w1_ld/i_b_ld  weight and bias load values
//   i_k0, i_k1, i_a, i_t  perceptron inputs, activation and target, captured on start
//   o_w0, o_w1, o_bias    current weights driving the perceptron
//   o_delta               most recent output delta, for the upstream backprop stage
//   o_busy, o_done        registered status: busy while updating, one-cycle commit pulse
module perceptron_update #(
    parameter logic [31:0] W0_INIT = 32'h00000000,
    parameter logic [31:0] W1_INIT = 32'h00000000,
    parameter logic [31:0] B_INIT  = 32'h00000000,
    parameter logic [31:0] LR      = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_load,
    input  logic [31:0] i_w0_ld,
    input  logic [31:0] i_w1_ld,
    input  logic [31:0] i_b_ld,
    input  logic [31:0] i_k0,
    input  logic [31:0] i_k1,
    input  logic [31:0] i_a,
    input  logic [31:0] i_t,
    output logic [31:0] o_w0,
    output logic [31:0] o_w1,
    output logic [31:0] o_bias,
    output logic [31:0] o_delta,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [31:0] ONE     = 32'h01000000;
    localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [31:0] SAT_NEG = 32'h80000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERR,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_MUL4,
        S_MUL5,
        S_UPD,
        S_DONE
    } state_t;

    state_t      r_state;

    // Operands captured on start
    logic [31:0] r_k0;
    logic [31:0] r_k1;
    logic [31:0] r_a;
    logic [31:0] r_t;

    // Intermediate results, one per state
    logic [31:0] r_e;      // a - t
    logic [31:0] r_m;      // 1 - a
    logic [31:0] r_g;      // sigmoid derivative a*(1-a)
    logic [31:0] r_delta;  // e * g
    logic [31:0] r_s;      // LR * delta, also the bias step
    logic [31:0] r_g0;     // s * k0
    logic [31:0] r_g1;     // s * k1

    // Architectural state
    logic [31:0] r_w0;
    logic [31:0] r_w1;
    logic [31:0] r_b;
    logic        r_busy;
    logic        r_done;

    // Shared multiplier
    logic [31:0]        w_mul_x;
    logic [31:0]        w_mul_y;
    logic signed [63:0] w_mul_xe;
    logic signed [63:0] w_mul_ye;
    logic signed [63:0] w_mul_p;
    logic [31:0]        w_mul_r;

    // Q8.24 product: keep bits [55:24]; the discarded upper bits must all
    // match the sign, otherwise the value is out of range and clamps.
    function automatic logic [31:0] sat_mul(input logic signed [63:0] p);
        logic [31:0] res;
        if (p[63:55] == {9{p[63]}}) begin
            res = p[55:24];
        end else if (p[63]) begin
            res = SAT_NEG;
        end else begin
            res = SAT_POS;
        end
        return res;
    endfunction

    // 33-bit difference; overflow shows up as bit 32 disagreeing with bit 31.
    function automatic logic [31:0] sat_sub(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] d;
        logic [31:0] res;
        d = {x[31], x} - {y[31], y};
        if (d[32] == d[31]) begin
            res = d[31:0];
        end else if (d[32]) begin
            res = SAT_NEG;
        end else begin
            res = SAT_POS;
        end
        return res;
    endfunction

    // Operand selection: each multiply state owns the multiplier for its cycle.
    always_comb begin
        w_mul_x = 32'h0;
        w_mul_y = 32'h0;
        case (r_state)
            S_MUL1: begin
                w_mul_x = r_a;
                w_mul_y = r_m;
            end
            S_MUL2: begin
                w_mul_x = r_e;
                w_mul_y = r_g;
            end
            S_MUL3: begin
                w_mul_x = LR;
                w_mul_y = r_delta;
            end
            S_MUL4: begin
                w_mul_x = r_s;
                w_mul_y = r_k0;
            end
            S_MUL5: begin
                w_mul_x = r_s;
                w_mul_y = r_k1;
            end
            default: begin
                w_mul_x = 32'h0;
                w_mul_y = 32'h0;
            end
        endcase
    end

    // Sign-extend to 64 bits so the low 64 bits of the product are the exact signed result.
    assign w_mul_xe = {{32{w_mul_x[31]}}, w_mul_x};
    assign w_mul_ye = {{32{w_mul_y[31]}}, w_mul_y};
    assign w_mul_p  = w_mul_xe * w_mul_ye;
    assign w_mul_r  = sat_mul(w_mul_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k0    <= 32'h0;
            r_k1    <= 32'h0;
            r_a     <= 32'h0;
            r_t     <= 32'h0;
            r_e     <= 32'h0;
            r_m     <= 32'h0;
            r_g     <= 32'h0;
            r_delta <= 32'h0;
            r_s     <= 32'h0;
            r_g0    <= 32'h0;
            r_g1    <= 32'h0;
            r_w0    <= W0_INIT;
            r_w1    <= W1_INIT;
            r_b     <= B_INIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Status outputs are registered views of the state, one cycle
            // behind it: busy covers cycles 1..8 after the start edge and the
            // done pulse lands in cycle 8, after the weights have settled.
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (i_load) begin
                        // Load takes priority; a simultaneous start is dropped.
                        r_w0 <= i_w0_ld;
                        r_w1 <= i_w1_ld;
                        r_b  <= i_b_ld;
                    end else if (i_start) begin
                        r_k0    <= i_k0;
                        r_k1    <= i_k1;
                        r_a     <= i_a;
                        r_t     <= i_t;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_e     <= sat_sub(r_a, r_t);
                    r_m     <= sat_sub(ONE, r_a);
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    r_g     <= w_mul_r;
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_delta <= w_mul_r;
                    r_state <= S_MUL3;
                end
                S_MUL3: begin
                    r_s     <= w_mul_r;
                    r_state <= S_MUL4;
                end
                S_MUL4: begin
                    r_g0    <= w_mul_r;
                    r_state <= S_MUL5;
                end
                S_MUL5: begin
                    r_g1    <= w_mul_r;
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    r_w0    <= sat_sub(r_w0, r_g0);
                    r_w1    <= sat_sub(r_w1, r_g1);
                    r_b     <= sat_sub(r_b, r_s);
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_w0    = r_w0;
    assign o_w1    = r_w1;
    assign o_bias  = r_b;
    assign o_delta = r_delta;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_perceptron_update.sv
// Purpose : directed self-checking bench for perceptron_update.
// Latency : checks done pulse at cycle 8 after the start edge, busy over cycles 1..8.
// Backpr. : exercises start/load being ignored while busy and load priority in idle.
module tb_perceptron_update;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_load;
    logic [31:0] i_w0_ld;
    logic [31:0] i_w1_ld;
    logic [31:0] i_b_ld;
    logic [31:0] i_k0;
    logic [31:0] i_k1;
    logic [31:0] i_a;
    logic [31:0] i_t;
    logic [31:0] o_w0;
    logic [31:0] o_w1;
    logic [31:0] o_bias;
    logic [31:0] o_delta;
    logic        o_busy;
    logic        o_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    perceptron_update #(
        .W0_INIT(32'h00100000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_start(i_start),
        .i_load (i_load),
        .i_w0_ld(i_w0_ld),
        .i_w1_ld(i_w1_ld),
        .i_b_ld (i_b_ld),
        .i_k0   (i_k0),
        .i_k1   (i_k1),
        .i_a    (i_a),
        .i_t    (i_t),
        .o_w0   (o_w0),
        .o_w1   (o_w1),
        .o_bias (o_bias),
        .o_delta(o_delta),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] b);
        i_w0_ld = w0;
        i_w1_ld = w1;
        i_b_ld  = b;
        i_load  = 1'b1;
        step();
        i_load  = 1'b0;
    endtask

    // One update; records busy/done per cycle (cycle c = cycle after edge Ec).
    // Operand inputs are scrambled right after capture. With pulse set, start
    // and load are raised during cycle 3 only.
    task automatic run_update(input string tag, input logic [31:0] k0, input logic [31:0] k1,
                              input logic [31:0] a, input logic [31:0] t, input bit pulse);
        logic [10:0] busy_seen;
        int          n_done;
        int          done_at;
        i_k0    = k0;
        i_k1    = k1;
        i_a     = a;
        i_t     = t;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        busy_seen    = '0;
        busy_seen[0] = o_busy;
        n_done  = 0;
        done_at = -1;
        i_k0 = ~k0;
        i_k1 = ~k1;
        i_a  = ~a;
        i_t  = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            step();
            i_start = 1'b0;
            i_load  = 1'b0;
            if (pulse && c == 3) begin
                i_w0_ld = 32'h12345678;
                i_w1_ld = 32'h12345678;
                i_b_ld  = 32'h12345678;
                i_start = 1'b1;
                i_load  = 1'b1;
            end
            busy_seen[c] = o_busy;
            if (o_done) begin
                n_done++;
                done_at = c;
            end
        end
        chk({tag, " busy_cycles"}, 32'(busy_seen), 32'h000001FE);
        chk({tag, " done_count"}, 32'(n_done), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_at), 32'd8);
    endtask

    initial begin
        int n_done_late;
        int n_busy_late;

        rst     = 1'b1;
        i_start = 1'b0;
        i_load  = 1'b0;
        i_w0_ld = 32'h0;
        i_w1_ld = 32'h0;
        i_b_ld  = 32'h0;
        i_k0    = 32'h0;
        i_k1    = 32'h0;
        i_a     = 32'h0;
        i_t     = 32'h0;

        // Reset state and hold
        step();
        step();
        rst = 1'b0;
        chk("rst w0", o_w0, 32'h00100000);
        chk("rst w1", o_w1, 32'h00000000);
        chk("rst bias", o_bias, 32'h00000000);
        chk("rst delta", o_delta, 32'h00000000);
        chk("rst busy", {31'h0, o_busy}, 32'h0);
        chk("rst done", {31'h0, o_done}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold w0", o_w0, 32'h00100000);
            chk("hold busy", {31'h0, o_busy}, 32'h0);
        end

        // Basic update: e=-0.5, g=0.25, delta=-0.125, s=-1/32
        do_load(32'h00800000, 32'h00400000, 32'h00000000);
        chk("load w0", o_w0, 32'h00800000);
        chk("load w1", o_w1, 32'h00400000);
        run_update("upd1", 32'h01000000, 32'h00000000, 32'h00800000, 32'h01000000, 1'b0);
        chk("upd1 delta", o_delta, 32'hFFE00000);
        chk("upd1 w0", o_w0, 32'h00880000);
        chk("upd1 w1", o_w1, 32'h00400000);
        chk("upd1 bias", o_bias, 32'h00080000);

        // Zero error: delta is zero and weights hold
        run_update("zero", 32'h01230000, 32'hFF000000, 32'h00800000, 32'h00800000, 1'b0);
        chk("zero delta", o_delta, 32'h00000000);
        chk("zero w0", o_w0, 32'h00880000);
        chk("zero w1", o_w1, 32'h00400000);
        chk("zero bias", o_bias, 32'h00080000);

        // Start/load pulsed while busy are ignored
        do_load(32'h00800000, 32'h00400000, 32'h00000000);
        run_update("busy", 32'h01000000, 32'h00000000, 32'h00800000, 32'h01000000, 1'b1);
        chk("busy delta", o_delta, 32'hFFE00000);
        chk("busy w0", o_w0, 32'h00880000);
        chk("busy w1", o_w1, 32'h00400000);
        chk("busy bias", o_bias, 32'h00080000);

        // Load and start together in idle: load wins, no update starts
        i_w0_ld = 32'h11111111;
        i_w1_ld = 32'h22222222;
        i_b_ld  = 32'h33333333;
        i_load  = 1'b1;
        i_start = 1'b1;
        step();
        i_load  = 1'b0;
        i_start = 1'b0;
        chk("both w0", o_w0, 32'h11111111);
        chk("both w1", o_w1, 32'h22222222);
        chk("both bias", o_bias, 32'h33333333);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("both busy", {31'h0, o_busy}, 32'h0);
            chk("both done", {31'h0, o_done}, 32'h0);
        end

        // Saturation: g0 = (-1/32)*(-128) = 4.0; w0 - 4.0 underflows and clamps
        do_load(32'h80010000, 32'h00000000, 32'h00000000);
        run_update("sat", 32'h80000000, 32'h00000000, 32'h00800000, 32'h01000000, 1'b0);
        chk("sat w0", o_w0, 32'h80000000);
        chk("sat w1", o_w1, 32'h00000000);
        chk("sat bias", o_bias, 32'h00080000);

        // Reset during MUL3 (cycle 3) discards the update
        i_k0    = 32'h01000000;
        i_k1    = 32'h00000000;
        i_a     = 32'h00800000;
        i_t     = 32'h01000000;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst w0", o_w0, 32'h00100000);
        chk("mrst w1", o_w1, 32'h00000000);
        chk("mrst bias", o_bias, 32'h00000000);
        chk("mrst delta", o_delta, 32'h00000000);
        chk("mrst busy", {31'h0, o_busy}, 32'h0);
        n_done_late = 0;
        n_busy_late = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_done) n_done_late++;
            if (o_busy) n_busy_late++;
        end
        chk("mrst no_done", 32'(n_done_late), 32'd0);
        chk("mrst no_busy", 32'(n_busy_late), 32'd0);

        // Fresh update from the init weights
        run_update("fresh", 32'h01000000, 32'h00000000, 32'h00800000, 32'h01000000, 1'b0);
        chk("fresh delta", o_delta, 32'hFFE00000);
        chk("fresh w0", o_w0, 32'h00180000);
        chk("fresh w1", o_w1, 32'h00000000);
        chk("fresh bias", o_bias, 32'h00080000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perceptron_update.md
Name: perceptron_update

Overview:
Sequential gradient-descent update stage placed directly downstream of the two-input perceptron. It consumes the perceptron's activation plus the same inputs and a target. It computes the sigmoid output delta and updates the weight/bias registers that drive the perceptron's i_w0/i_w1/i_bias. All data is signed Q8.24: 32 bits, with 8 integer bits (including sign) and 24 fraction bits. One shared multiplier is used, one multiply per state.

Parameters:
W0_INIT, 32'h00000000, reset value of o_w0 (Q8.24)
W1_INIT, 32'h00000000, reset value of o_w1 (Q8.24)
B_INIT, 32'h00000000, reset value of o_bias (Q8.24)
LR, 32'h00400000, learning rate (0.25 in Q8.24)

Ports:
clk  in  1  clock, all state changes on the rising edge
rst  in  1  synchronous, active-high reset
i_start  in  1  request one update; sampled only in IDLE
i_load  in  1  load weight registers from i_w*_ld; sampled only in IDLE
i_w0_ld  in  32  w0 load value
i_w1_ld  in  32  w1 load value
i_b_ld  in  32  bias load value
i_k0  in  32  perceptron input 0, captured on start
i_k1  in  32  perceptron input 1, captured on start
i_a  in  32  perceptron activation o_a, captured on start
i_t  in  32  target, captured on start
o_w0  out  32  current w0, registered
o_w1  out  32  current w1, registered
o_bias  out  32  current bias, registered
o_delta  out  32  last output delta, for the upstream backprop stage
o_busy  out  1  high in every non-IDLE state
o_done  out  1  one-cycle pulse when the update is committed

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-update:
  - o_w0=W0_INIT, o_w1=W1_INIT, o_bias=B_INIT
  - o_delta=0, o_busy=0, o_done=0, state=IDLE
  - the pending update is discarded and no o_done is issued.
- Arithmetic:
  - mul(x,y): full 64-bit signed product, result = product[55:24] (arithmetic truncation toward -inf).
  - If product[63:55] are not all equal, the result saturates to 32'h7FFFFFFF (positive) or 32'h80000000 (negative).
  - add/sub: 33-bit signed result, saturated to the same limits.
  - 1.0 = 32'h01000000.
- FSM, one state per cycle:
  - IDLE: if i_load, then w0/w1/b <= load values. Else if i_start, capture k0,k1,a,t into internal registers and go to ERR. When i_load and i_start are both high, load wins and start is dropped.
  - ERR: e = sub(a,t); m = sub(1.0,a) -> MUL1
  - MUL1: g = mul(a,m) -> MUL2
  - MUL2: delta = mul(e,g); o_delta <= delta -> MUL3
  - MUL3: s = mul(LR,delta) -> MUL4
  - MUL4: g0 = mul(s,k0) -> MUL5
  - MUL5: g1 = mul(s,k1) -> UPD
  - UPD: w0 <= sub(w0,g0); w1 <= sub(w1,g1); b <= sub(b,s) -> DONE
  - DONE: o_done=1 for exactly this cycle -> IDLE
- Latency:
  - Start is accepted at edge E0; o_done is high in the cycle following edge E8.
  - Updated weights are visible from the cycle following edge E7, so they are already stable while o_done is high.
  - A new start is accepted at the edge that ends DONE+1 (IDLE), giving a minimum interval of 9 cycles.
- While busy, i_start and i_load are ignored and not queued. Changes on i_k*/i_a/i_t after capture have no effect.
- o_busy and o_done are registered. o_busy is 0 in IDLE only; it stays 1 in DONE.
- Weights change only in UPD, on load, or on reset.

Test Plan:
- Reset with W0_INIT=32'h00100000, default LR: o_w0=32'h00100000, o_w1=0, o_bias=0, o_busy=0, o_done=0; hold 5 cycles and values stay unchanged.
- Load w0=32'h00800000, w1=32'h00400000, b=0. Start with k0=32'h01000000, k1=0, a=32'h00800000, t=32'h01000000.
  - o_delta=32'hFFE00000.
  - Result: o_w0=32'h00880000, o_w1=32'h00400000, o_bias=32'h00080000.
  - o_done pulses exactly once, 8 cycles after the start edge.
- a=t=32'h00800000 with any k: o_delta=0, weights unchanged, o_done still at cycle 8, o_busy high for cycles 1-8.
- Saturation: load w0=32'h80010000. Start with k0=32'h80000000, a=32'h00800000, t=32'h01000000, giving g0=32'h04000000. o_w0 saturates to 32'h80000000 (no wrap).
- Protocol while busy: during an update, pulse i_start and i_load (load values 32'h12345678) at cycle 3. Result matches a lone update, there is a single o_done, and no load occurs. i_load and i_start together in IDLE: load applied, o_busy stays 0.
- Reset asserted in MUL3: the next cycle shows weights = INIT values, o_delta=0, o_busy=0, and no o_done ever appears. A fresh start afterwards completes normally.
